// File: rtl/branch_target_predictor_if.sv
`timescale 1ns/1ps
// Fetch/execute-side signal bundle of the branch target predictor.
// Latency: lookup and redirect signals are combinational; training lands at the next clock edge.
// Backpressure: none; the pipeline presents one lookup and at most one resolution per cycle.
//   master: pipeline side (drives pcF and the E-stage resolution, receives prediction/redirect)
//   slave : predictor side
interface branch_target_predictor_if #(
   parameter int XLEN = 32
);
   // fetch-stage lookup
   logic            [XLEN-1:0] pcF;
   logic                       predTakenF;
   logic            [XLEN-1:0] predTargetF;
   // execute-stage resolution / training
   logic                       instValidE;
   logic                       updValidE;
   logic                       updIsJumpE;
   logic            [XLEN-1:0] updPcE;
   logic                       updTakenE;
   logic            [XLEN-1:0] updTargetE;
   logic                       updPredTakenE;
   logic            [XLEN-1:0] updPredTargetE;
   logic                       mispredictE;
   logic            [XLEN-1:0] correctPcE;

   modport master (
      output pcF, instValidE, updValidE, updIsJumpE, updPcE, updTakenE, updTargetE,
             updPredTakenE, updPredTargetE,
      input  predTakenF, predTargetF, mispredictE, correctPcE
   );

   modport slave (
      input  pcF, instValidE, updValidE, updIsJumpE, updPcE, updTakenE, updTargetE,
             updPredTakenE, updPredTargetE,
      output predTakenF, predTargetF, mispredictE, correctPcE
   );
endinterface

// File: rtl/branch_target_predictor.sv
`timescale 1ns/1ps
// Direct-mapped BTB with 2-bit direction counters, mispredict detection and saturating statistics.
// Latency: 0-cycle combinational lookup/redirect; table training and counters update at posedge clk.
// Backpressure: none; accepts one lookup and one resolution every cycle.
//   clk, rst (async, active low) ; bus (slave modport): fetch lookup + E-stage resolution
//   branchCount / mispredCount: saturating statistics
module branch_target_predictor #(
   parameter int XLEN    = 32,
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 8,
   parameter int STAT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   branch_target_predictor_if.slave bus,
   output logic [STAT_W-1:0]       branchCount,
   output logic [STAT_W-1:0]       mispredCount
);
   localparam int              ENTRIES = 2**INDEX_W;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic                valid_q  [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [XLEN-1:0]     target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];
   logic [STAT_W-1:0]   branch_cnt_q, branch_cnt_d;
   logic [STAT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

   // ---------------- fetch lookup ----------------
   logic [INDEX_W-1:0]  idx_f;
   logic [TAG_W-1:0]    tag_f;
   logic                hit_f;
   logic                pred_taken_f;

   assign idx_f        = bus.pcF[INDEX_W+1:2];
   assign tag_f        = bus.pcF[INDEX_W+TAG_W+1:INDEX_W+2];
   // Reset clears valid asynchronously, so the lookup falls back to pc+4 while rst=0.
   assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_taken_f = hit_f && ctr_q[idx_f][1];

   assign bus.predTakenF  = pred_taken_f;
   assign bus.predTargetF = pred_taken_f ? target_q[idx_f] : bus.pcF + PC_STEP;

   // ---------------- execute training ----------------
   logic [INDEX_W-1:0]  idx_e;
   logic [TAG_W-1:0]    tag_e;
   logic                hit_e;
   logic                upd_fire;
   logic                write_d;
   logic [XLEN-1:0]     target_d;
   logic [1:0]          ctr_d;

   assign idx_e    = bus.updPcE[INDEX_W+1:2];
   assign tag_e    = bus.updPcE[INDEX_W+TAG_W+1:INDEX_W+2];
   assign hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign upd_fire = bus.instValidE && bus.updValidE;

   always_comb begin
      write_d  = 1'b0;
      target_d = target_q[idx_e];
      ctr_d    = ctr_q[idx_e];
      if (upd_fire) begin
         if (hit_e) begin
            write_d = 1'b1;
            if (bus.updIsJumpE) begin
               ctr_d    = 2'b11;
               target_d = bus.updTargetE;
            end else if (bus.updTakenE) begin
               ctr_d    = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'b01;
               target_d = bus.updTargetE;
            end else begin
               ctr_d    = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'b01;
            end
         end else if (bus.updTakenE) begin
            // Allocation overwrites whatever occupied this index.
            write_d  = 1'b1;
            target_d = bus.updTargetE;
            ctr_d    = bus.updIsJumpE ? 2'b11 : 2'b10;
         end
      end
   end

   // ---------------- mispredict / redirect ----------------
   logic mispred_raw;

   always_comb begin
      mispred_raw = 1'b0;
      if (bus.instValidE) begin
         if (bus.updValidE) begin
            mispred_raw = (bus.updTakenE != bus.updPredTakenE) ||
                          (bus.updTakenE && (bus.updTargetE != bus.updPredTargetE));
         end else begin
            // A non-branch that fetch predicted taken (tag alias) must be redirected to pc+4.
            mispred_raw = bus.updPredTakenE;
         end
      end
   end

   assign bus.mispredictE = rst && mispred_raw;
   assign bus.correctPcE  = (bus.updValidE && bus.updTakenE) ? bus.updTargetE
                                                            : bus.updPcE + PC_STEP;

   // ---------------- statistics ----------------
   // Counters are held at zero during reset, so the ungated mispredict term is safe here.
   assign branch_cnt_d  = (upd_fire && (branch_cnt_q != '1)) ? branch_cnt_q + STAT_W'(1)
                                                             : branch_cnt_q;
   assign mispred_cnt_d = (mispred_raw && (mispred_cnt_q != '1)) ? mispred_cnt_q + STAT_W'(1)
                                                                 : mispred_cnt_q;
   assign branchCount   = branch_cnt_q;
   assign mispredCount  = mispred_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (write_d) begin
            valid_q[idx_e]  <= 1'b1;
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= target_d;
            ctr_q[idx_e]    <= ctr_d;
         end
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
`timescale 1ns/1ps
// Bench for branch_target_predictor: directed scenarios plus randomized traffic against a table model.
// A second instance with STAT_W=2 shares every input to exercise statistics saturation.
module tb_branch_target_predictor;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   branch_target_predictor_if #(.XLEN(32)) bif();
   branch_target_predictor_if #(.XLEN(32)) sif();
   logic [31:0] branchCount, mispredCount;
   logic [1:0]  sBranchCount, sMispredCount;

   branch_target_predictor #(.XLEN(32), .INDEX_W(4), .TAG_W(8), .STAT_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bif.slave), .branchCount(branchCount), .mispredCount(mispredCount));

   branch_target_predictor #(.XLEN(32), .INDEX_W(4), .TAG_W(8), .STAT_W(2)) dut_small (
      .clk(clk), .rst(rst), .bus(sif.slave), .branchCount(sBranchCount), .mispredCount(sMispredCount));

   assign sif.pcF            = bif.pcF;
   assign sif.instValidE     = bif.instValidE;
   assign sif.updValidE      = bif.updValidE;
   assign sif.updIsJumpE     = bif.updIsJumpE;
   assign sif.updPcE         = bif.updPcE;
   assign sif.updTakenE      = bif.updTakenE;
   assign sif.updTargetE     = bif.updTargetE;
   assign sif.updPredTakenE  = bif.updPredTakenE;
   assign sif.updPredTargetE = bif.updPredTargetE;

   // ---------------- reference model ----------------
   bit          m_valid  [16];
   logic [7:0]  m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];
   int          m_branches, m_mispred;

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic logic [7:0] m_tagof(input logic [31:0] pc);
      return 8'((pc / 64) % 256);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   function automatic bit exp_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
   endfunction

   function automatic logic [31:0] exp_target(input logic [31:0] pc);
      return exp_taken(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
   endfunction

   function automatic bit exp_mispred();
      if (!bif.instValidE) return 1'b0;
      if (bif.updValidE)
         return (bif.updTakenE != bif.updPredTakenE) ||
                (bif.updTakenE && (bif.updTargetE != bif.updPredTargetE));
      return bif.updPredTakenE;
   endfunction

   function automatic logic [31:0] exp_correct();
      return (bif.updValidE && bif.updTakenE) ? bif.updTargetE : bif.updPcE + 32'd4;
   endfunction

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 1;
      end
      m_branches = 0;
      m_mispred  = 0;
   endtask

   task automatic model_commit();
      int i;
      i = m_idx(bif.updPcE);
      if (exp_mispred()) m_mispred++;
      if (bif.instValidE && bif.updValidE) begin
         m_branches++;
         if (m_hit(bif.updPcE)) begin
            if (bif.updIsJumpE) begin
               m_ctr[i] = 3; m_target[i] = bif.updTargetE;
            end else if (bif.updTakenE) begin
               m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
               m_target[i] = bif.updTargetE;
            end else begin
               m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (bif.updTakenE) begin
            m_valid[i] = 1'b1; m_tag[i] = m_tagof(bif.updPcE);
            m_target[i] = bif.updTargetE; m_ctr[i] = bif.updIsJumpE ? 3 : 2;
         end
      end
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic set_e(input bit iv, input bit uv, input bit jmp, input logic [31:0] pc,
                        input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
      bif.instValidE = iv; bif.updValidE = uv; bif.updIsJumpE = jmp; bif.updPcE = pc;
      bif.updTakenE = tk; bif.updTargetE = tgt; bif.updPredTakenE = ptk; bif.updPredTargetE = ptgt;
   endtask

   task automatic set_idle();
      set_e(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Advance one clock; model follows the DUT only when out of reset. Ends 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) model_commit();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_idle();
      model_clear();
      tick();
      rst = 1'b1;
      #2;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] t, ix;
      t  = 32'($urandom_range(1, 3));
      ix = 32'($urandom_range(0, 15));
      return (t << 6) | (ix << 2);
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      model_clear();
      set_e(1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0);
      bif.pcF = 32'h100;
      #2;
      tests_run++; if (bif.predTakenF !== 1'b0) begin tests_failed++; $display("FAIL reset_predTaken: got %0b want 0", bif.predTakenF); end
      tests_run++; if (bif.predTargetF !== 32'h104) begin tests_failed++; $display("FAIL reset_predTarget: got %h want 00000104", bif.predTargetF); end
      tests_run++; if (bif.mispredictE !== 1'b0) begin tests_failed++; $display("FAIL reset_mispredict: got %0b want 0", bif.mispredictE); end
      tick();
      tests_run++; if (branchCount !== 32'd0 || mispredCount !== 32'd0) begin tests_failed++; $display("FAIL reset_counts: got %0d/%0d want 0/0", branchCount, mispredCount); end
      set_idle();
      rst = 1'b1;
      #2;
   endtask

   task automatic test_train();
      bif.pcF = 32'h100;
      set_e(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      #2;
      tests_run++; if (bif.mispredictE !== 1'b1) begin tests_failed++; $display("FAIL train_mispredict: got %0b want 1", bif.mispredictE); end
      tests_run++; if (bif.correctPcE !== 32'h80) begin tests_failed++; $display("FAIL train_correctPc: got %h want 00000080", bif.correctPcE); end
      tests_run++; if (bif.predTakenF !== 1'b0) begin tests_failed++; $display("FAIL train_preupdate: got %0b want 0", bif.predTakenF); end
      tick();
      set_idle();
      #2;
      tests_run++; if (bif.predTakenF !== 1'b1) begin tests_failed++; $display("FAIL train_predTaken: got %0b want 1", bif.predTakenF); end
      tests_run++; if (bif.predTargetF !== 32'h80) begin tests_failed++; $display("FAIL train_predTarget: got %h want 00000080", bif.predTargetF); end
      tests_run++; if (branchCount !== 32'd1 || mispredCount !== 32'd1) begin tests_failed++; $display("FAIL train_counts: got %0d/%0d want 1/1", branchCount, mispredCount); end
   endtask

   task automatic test_hysteresis();
      bit outcome [11] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
      bit expect_p[11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
      bif.pcF = 32'h100;
      for (int k = 0; k < 11; k++) begin
         set_e(1'b1, 1'b1, 1'b0, 32'h100, outcome[k], 32'h80, exp_taken(32'h100), exp_target(32'h100));
         tick();
         set_idle();
         #2;
         tests_run++;
         if (bif.predTakenF !== expect_p[k]) begin
            tests_failed++;
            $display("FAIL hyst_step%0d: predTaken got %0b want %0b", k, bif.predTakenF, expect_p[k]);
         end
      end
      tests_run++; if (branchCount !== 32'(m_branches)) begin tests_failed++; $display("FAIL hyst_branchCount: got %0d want %0d", branchCount, m_branches); end
   endtask

   task automatic test_alias();
      // Retrain 0x100 so its index is occupied by a taken entry with a different tag.
      set_e(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, exp_taken(32'h100), exp_target(32'h100));
      tick();
      bif.pcF = 32'h140;
      set_e(1'b1, 1'b0, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h80);
      #2;
      tests_run++; if (bif.predTakenF !== 1'b0) begin tests_failed++; $display("FAIL alias_predTaken: got %0b want 0", bif.predTakenF); end
      tests_run++; if (bif.predTargetF !== 32'h144) begin tests_failed++; $display("FAIL alias_predTarget: got %h want 00000144", bif.predTargetF); end
      tests_run++; if (bif.mispredictE !== 1'b1) begin tests_failed++; $display("FAIL alias_mispredict: got %0b want 1", bif.mispredictE); end
      tests_run++; if (bif.correctPcE !== 32'h144) begin tests_failed++; $display("FAIL alias_correctPc: got %h want 00000144", bif.correctPcE); end
      tick();
      set_idle();
      #2;
      tests_run++; if (branchCount !== 32'(m_branches) || mispredCount !== 32'(m_mispred)) begin tests_failed++; $display("FAIL alias_counts: got %0d/%0d want %0d/%0d", branchCount, mispredCount, m_branches, m_mispred); end
   endtask

   task automatic test_target_change();
      set_e(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h280, 1'b0, 32'h204);
      tick();
      bif.pcF = 32'h200;
      set_e(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h280);
      #2;
      tests_run++; if (bif.mispredictE !== 1'b1) begin tests_failed++; $display("FAIL tchg_mispredict: got %0b want 1", bif.mispredictE); end
      tests_run++; if (bif.correctPcE !== 32'h300) begin tests_failed++; $display("FAIL tchg_correctPc: got %h want 00000300", bif.correctPcE); end
      tests_run++; if (bif.predTargetF !== 32'h280) begin tests_failed++; $display("FAIL tchg_samecycle: got %h want 00000280", bif.predTargetF); end
      tick();
      set_idle();
      #2;
      tests_run++; if (bif.predTargetF !== 32'h300) begin tests_failed++; $display("FAIL tchg_newtarget: got %h want 00000300", bif.predTargetF); end
   endtask

   task automatic test_wrap();
      bif.pcF = 32'hFFFF_FFFC;
      set_e(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
      #2;
      tests_run++; if (bif.predTargetF !== 32'h0) begin tests_failed++; $display("FAIL wrap_predTarget: got %h want 00000000", bif.predTargetF); end
      tests_run++; if (bif.correctPcE !== 32'h0) begin tests_failed++; $display("FAIL wrap_correctPc: got %h want 00000000", bif.correctPcE); end
      tests_run++; if (bif.mispredictE !== 1'b0) begin tests_failed++; $display("FAIL wrap_mispredict: got %0b want 0", bif.mispredictE); end
      tick();
      set_idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pe, pf, tg, ptg;
         bit iv, uv, jm, tk, ptk;
         pe  = rand_pc();
         pf  = ($urandom_range(0, 3) == 0) ? pe : rand_pc();
         iv  = ($urandom_range(0, 9) != 0);
         uv  = ($urandom_range(0, 3) != 0);
         jm  = uv && ($urandom_range(0, 4) == 0);
         tk  = jm || ($urandom_range(0, 2) != 0);
         tg  = 32'($urandom_range(0, 7)) << 4;
         ptk = ($urandom_range(0, 3) != 0) ? exp_taken(pe) : 1'($urandom_range(0, 1));
         ptg = ($urandom_range(0, 3) != 0) ? exp_target(pe) : tg;
         bif.pcF = pf;
         set_e(iv, uv, jm, pe, tk, tg, ptk, ptg);
         #2;
         tests_run++; if (bif.predTakenF !== exp_taken(pf)) begin tests_failed++; $display("FAIL rnd%0d_predTaken: got %0b want %0b", n, bif.predTakenF, exp_taken(pf)); end
         tests_run++; if (bif.predTargetF !== exp_target(pf)) begin tests_failed++; $display("FAIL rnd%0d_predTarget: got %h want %h", n, bif.predTargetF, exp_target(pf)); end
         tests_run++; if (bif.mispredictE !== exp_mispred()) begin tests_failed++; $display("FAIL rnd%0d_mispredict: got %0b want %0b", n, bif.mispredictE, exp_mispred()); end
         tests_run++; if (bif.correctPcE !== exp_correct()) begin tests_failed++; $display("FAIL rnd%0d_correctPc: got %h want %h", n, bif.correctPcE, exp_correct()); end
         tick();
         tests_run++; if (branchCount !== 32'(m_branches) || mispredCount !== 32'(m_mispred)) begin tests_failed++; $display("FAIL rnd%0d_counts: got %0d/%0d want %0d/%0d", n, branchCount, mispredCount, m_branches, m_mispred); end
         tests_run++; if (sBranchCount !== 2'(sat3(m_branches)) || sMispredCount !== 2'(sat3(m_mispred))) begin tests_failed++; $display("FAIL rnd%0d_smallcounts: got %0d/%0d want %0d/%0d", n, sBranchCount, sMispredCount, sat3(m_branches), sat3(m_mispred)); end
      end
      set_idle();
   endtask

   task automatic test_reset_midop();
      set_e(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, exp_taken(32'h100), exp_target(32'h100));
      tick();
      bif.pcF = 32'h100;
      set_e(1'b1, 1'b1, 1'b0, 32'h340, 1'b1, 32'h90, 1'b0, 32'h344);
      #2;
      tests_run++; if (bif.predTakenF !== 1'b1) begin tests_failed++; $display("FAIL midrst_trained: got %0b want 1", bif.predTakenF); end
      rst = 1'b0;
      model_clear();
      #1;
      tests_run++; if (bif.predTakenF !== 1'b0) begin tests_failed++; $display("FAIL midrst_predTaken: got %0b want 0", bif.predTakenF); end
      tests_run++; if (bif.predTargetF !== 32'h104) begin tests_failed++; $display("FAIL midrst_predTarget: got %h want 00000104", bif.predTargetF); end
      tests_run++; if (bif.mispredictE !== 1'b0) begin tests_failed++; $display("FAIL midrst_mispredict: got %0b want 0", bif.mispredictE); end
      tests_run++; if (branchCount !== 32'd0 || sBranchCount !== 2'd0) begin tests_failed++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", branchCount, sBranchCount); end
      tick();
      set_idle();
      rst = 1'b1;
      bif.pcF = 32'h340;
      #2;
      tests_run++; if (bif.predTakenF !== 1'b0) begin tests_failed++; $display("FAIL midrst_discarded: got %0b want 0", bif.predTakenF); end
   endtask

   task automatic test_stat_sat();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_e(1'b1, 1'b1, 1'b0, 32'h500, 1'b0, 32'h0, 1'b0, 32'h504);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         set_e(1'b1, 1'b0, 1'b0, 32'h600, 1'b0, 32'h0, 1'b1, 32'h700);
         tick();
      end
      set_idle();
      #2;
      tests_run++; if (sBranchCount !== 2'd3) begin tests_failed++; $display("FAIL sat_branchSmall: got %0d want 3", sBranchCount); end
      tests_run++; if (sMispredCount !== 2'd3) begin tests_failed++; $display("FAIL sat_mispredSmall: got %0d want 3", sMispredCount); end
      tests_run++; if (branchCount !== 32'd5 || mispredCount !== 32'd4) begin tests_failed++; $display("FAIL sat_countsWide: got %0d/%0d want 5/4", branchCount, mispredCount); end
   endtask

   initial begin
      bif.pcF = 32'h0;
      set_idle();
      test_reset();
      test_train();
      test_hysteresis();
      test_alias();
      test_target_change();
      test_wrap();
      test_random();
      test_reset_midop();
      test_stat_sat();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch/jump predictor for the 5-stage RISC-V pipeline.
- Fetch stage looks up a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters to produce a predicted next PC.
- Execute stage resolves the branch, trains the tables, and flags mispredictions so the hazard unit flushes D/E only on a wrong guess, not on every taken branch.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
- XLEN, 32, PC/target width.
- INDEX_W, 4, BTB index bits; ENTRIES = 2**INDEX_W.
- TAG_W, 8, tag bits stored per entry; INDEX_W+TAG_W+2 <= XLEN is required.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pcF  in  XLEN  fetch-stage PC.
- predTakenF  out  1  predicted taken for pcF.
- predTargetF  out  XLEN  predicted next PC for pcF.
- instValidE  in  1  E stage holds a real (not flushed) instruction.
- updValidE  in  1  E instruction is a branch or jump; train the tables this cycle.
- updIsJumpE  in  1  E instruction is an unconditional jump (jal/jalr).
- updPcE  in  XLEN  PC of the E instruction.
- updTakenE  in  1  resolved direction.
- updTargetE  in  XLEN  resolved target.
- updPredTakenE  in  1  prediction carried down the pipeline with the instruction.
- updPredTargetE  in  XLEN  predicted target carried down the pipeline.
- mispredictE  out  1  redirect required.
- correctPcE  out  XLEN  redirect PC.
- branchCount  out  STAT_W  resolved branch/jump count.
- mispredCount  out  STAT_W  mispredict count.

Behaviour:
- Reset: asserting rst (rst=0) asynchronously sets all entry valid bits to 0, all counters to 2'b01, and both statistics counters to 0.
  - While rst=0, predTakenF=0, predTargetF=pcF+4, mispredictE=0.
- Indexing: index = pc[INDEX_W+1:2]; tag = pc[INDEX_W+TAG_W+1:INDEX_W+2].
- Each entry holds: valid (1), tag (TAG_W), target (XLEN), ctr (2).
- Lookup is combinational with 0-cycle latency.
  - hit = valid[idx] && tag[idx]==tagF.
  - predTakenF = hit && ctr[idx][1].
  - predTargetF = predTakenF ? target[idx] : pcF+4.
- Update is registered at the posedge when updValidE && instValidE.
  - Hit and updIsJumpE: ctr<=2'b11, target<=updTargetE.
  - Hit, conditional branch: taken increments ctr, saturating at 2'b11; not taken decrements, saturating at 2'b00. target<=updTargetE only when taken.
  - Miss and taken: allocate (overwrite) the entry. valid<=1, tag, target<=updTargetE, ctr<=2'b11 for a jump, otherwise 2'b10.
  - Miss and not taken: no table write.
- Same-cycle lookup and update of the same entry: lookup returns pre-update contents (no bypass). The new contents are visible the next cycle.
- Mispredict is combinational; all terms below are gated by instValidE, and mispredictE=0 when instValidE=0.
  - When updValidE=1: mispredictE = (updTakenE != updPredTakenE) || (updTakenE && updTargetE != updPredTargetE).
  - When updValidE=0: mispredictE = updPredTakenE. This covers a non-branch predicted taken after tag aliasing.
- correctPcE = (updValidE && updTakenE) ? updTargetE : updPcE+4.
- Statistics, at each posedge:
  - branchCount increments when updValidE && instValidE.
  - mispredCount increments when mispredictE.
  - Both saturate at all-ones and never wrap.
- Arithmetic: the +4 additions are XLEN-bit modulo. The PC at all-ones-4 wraps to 0.
- Reset mid-operation: an update in flight at reset assertion is discarded; tables are cleared immediately.

Test Plan:
- Reset, pcF=0x100 -> predTakenF=0, predTargetF=0x104, both counts 0.
- Update: branch pc 0x100, taken, target 0x80, predTaken 0 -> mispredictE=1, correctPcE=0x80. Next cycle pcF=0x100 -> predTakenF=1, predTargetF=0x80, ctr=2'b10, branchCount=1, mispredCount=1.
- Hysteresis on pc 0x100:
  - not-taken -> ctr 2'b01, predict not taken.
  - taken -> ctr 2'b10, predict taken.
  - 3x taken -> ctr saturates at 2'b11.
  - 4x not-taken -> ctr saturates at 2'b00.
- Alias with INDEX_W=4: pcF=0x140 after training 0x100 -> tag miss, predTakenF=0, predTargetF=0x144. Update with instValidE=1, updValidE=0, updPredTakenE=1 -> mispredictE=1, correctPcE=updPcE+4.
- Target change: jump pc 0x200, updTakenE=1, updTargetE=0x300, updPredTakenE=1, updPredTargetE=0x280 -> mispredictE=1, correctPcE=0x300. Next cycle lookup pcF=0x200 -> predTargetF=0x300. Same-cycle lookup of 0x200 during the update -> old target 0x280.
- Assert rst=0 mid-sequence between clock edges -> outputs immediately revert to reset values. Previously trained pc 0x100 -> predTakenF=0. With STAT_W=2, 5 updates -> branchCount=3 (saturated).
